trace_checker: RTL and testbench
================================

TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  END_PC, 32'h1c000100, PC value whose appearance on debug_wb_pc ends the run.
  TRACE_AW, 16, trace ROM address width.
  STOP_ON_ERR, 1, if 1 the first mismatch ends the run in FAIL.
REQ-002 Ports, one per line (name, direction, width, meaning):
  clk, in, 1, sole clock, rising edge.
  reset, in, 1, synchronous, active-high reset.
  chk_en, in, 1, start checking; sampled only in IDLE.
  debug_wb_pc, in, 32, PC of the writeback instruction.
  debug_wb_rf_we, in, 4, per-byte register-file write enable.
  debug_wb_rf_wnum, in, 5, destination register number.
  debug_wb_rf_wdata, in, 32, write data.
  trace_ren, out, 1, trace ROM read strobe.
  trace_raddr, out, TRACE_AW, trace ROM entry index.
  trace_rdata, in, 69, entry {wnum[68:64], pc[63:32], wdata[31:0]}, valid the cycle after trace_ren.
  done, out, 1, run finished (PASS or FAIL).
  pass, out, 1, run finished with zero errors.
  err_cnt, out, 16, mismatch count, saturating.
  commit_cnt, out, 32, number of checked commits.
  err_pc, out, 32, debug_wb_pc of the first mismatch.
  err_wdata, out, 32, debug_wb_rf_wdata of the first mismatch.
  underflow, out, 1, sticky: a commit arrived while no expected entry was buffered.

Function
REQ-003 FSM states: IDLE, RUN, PASS, FAIL. Transitions: IDLE->RUN when chk_en=1; RUN->PASS/FAIL per REQ-009 and REQ-010. PASS and FAIL hold until reset.
REQ-004 Commit event: state==RUN, debug_wb_rf_we!=0 and debug_wb_rf_wnum!=0. Cycles with rf_we==0 or wnum==0 are ignored.
REQ-005 Prefetch: a 2-entry expected-entry buffer plus one in-flight read. In RUN, raise trace_ren with trace_raddr=rd_ptr when (occupancy + inflight - pop) < 2, then increment rd_ptr. Push trace_rdata into the buffer the next cycle. rd_ptr wraps modulo 2^TRACE_AW.
REQ-006 Steady state: one commit per cycle is sustained indefinitely with no underflow. A push and a pop in the same cycle are both honoured.
REQ-007 Compare on a commit, against the buffer head: pc equal, wnum equal, and wdata equal under the byte mask expanded from debug_wb_rf_we (rf_we[i] covers bits 8i+7:8i). The head is then popped and commit_cnt increments.
REQ-008 On mismatch: err_cnt increments and saturates at 16'hFFFF. On the first mismatch only, latch err_pc and err_wdata.
REQ-009 If STOP_ON_ERR=1, a mismatch moves the FSM RUN->FAIL on the next edge, and no further compares occur.
REQ-010 End: in RUN, debug_wb_pc==END_PC (regardless of rf_we) moves the FSM to PASS if the resulting err_cnt==0 and underflow==0; otherwise it moves to FAIL.
REQ-011 Simultaneous commit and END_PC: the compare is performed first, and its result is included in the PASS/FAIL decision.
REQ-012 Commit with an empty buffer: set underflow, increment err_cnt, no pop, FSM->FAIL.
REQ-013 done=1 in PASS or FAIL. pass=1 only in PASS. Both are registered outputs.
REQ-014 trace_ren=0 outside RUN. In-flight data arriving after leaving RUN is discarded.

Reset
REQ-015 On reset=1 at a clk edge: state=IDLE; rd_ptr, occupancy, inflight, err_cnt, commit_cnt, err_pc, err_wdata = 0; trace_ren, done, pass, underflow = 0. Reset mid-run discards all buffered and in-flight entries.

Structure
REQ-016 Package trace_chk_pkg holds the state encoding, the entry field offsets (WNUM_MSB=68, PC_LSB=32), the entry width 69 and the END_PC default.
REQ-017 Sub-module trace_prefetch_fifo: 2-entry, 69-bit, same-cycle push/pop, occupancy output. All other logic lives in trace_checker.

Verification
REQ-018 ROM of 8 correct entries; CPU model commits them on back-to-back cycles, then drives END_PC -> commit_cnt=8, err_cnt=0, done=1, pass=1.
REQ-019 Entry 3 wdata differs in bit 0, STOP_ON_ERR=1 -> err_cnt=1, err_pc=entry-3 pc, FAIL one cycle later, later commits not counted.
REQ-020 STOP_ON_ERR=0, two bad entries, then END_PC -> err_cnt=2, err_pc=first bad pc, done=1, pass=0.
REQ-021 Commit with rf_we=4'b0001 and an expected value differing only in bits 31:8 -> no error. Commit with wnum=0 -> ignored, commit_cnt unchanged.
REQ-022 Commit driven on the cycle after chk_en (buffer empty) -> underflow=1, FAIL. Reset during RUN with 2 entries buffered -> all outputs 0, IDLE, and the first post-reset read uses raddr=0.
REQ-023 TRACE_AW=3 with 10 commits -> trace_raddr wraps 7->0, and the wrapped entries are compared correctly.

Source files
------------

// File: rtl/trace_chk_pkg.sv
// Shared types and constants for the commit trace checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package trace_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_t;

    // Trace entry layout: {wnum[68:64], pc[63:32], wdata[31:0]}
    localparam int ENTRY_W   = 69;
    localparam int WNUM_MSB  = 68;
    localparam int WNUM_LSB  = 64;
    localparam int PC_MSB    = 63;
    localparam int PC_LSB    = 32;
    localparam int WDATA_MSB = 31;

    localparam logic [31:0] END_PC_DEFAULT = 32'h1c000100;

    // Expand a per-byte write enable into a 32-bit compare mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] we);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{we[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/trace_prefetch_fifo.sv
// Two-entry buffer of expected trace entries; head is the oldest entry.
// Latency: a pushed entry is visible at head on the following cycle.
// Backpressure: none; push into a full buffer is dropped unless a pop happens the same cycle.
module trace_prefetch_fifo
    import trace_chk_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [1:0]         occupancy
);

    logic [ENTRY_W-1:0] mem [2];
    logic               wr_idx;
    logic               rd_idx;
    logic               do_push;
    logic               do_pop;

    assign do_pop  = pop && (occupancy != 2'd0);
    assign do_push = push && ((occupancy != 2'd2) || do_pop);
    assign head    = mem[rd_idx];

    // Storage needs no reset: occupancy alone says which slots are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
    end

    // Pointer and occupancy tracking; same-cycle push and pop cancel in the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx    <= 1'b0;
            rd_idx    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (do_push) wr_idx <= ~wr_idx;
            if (do_pop)  rd_idx <= ~rd_idx;
            occupancy <= occupancy + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/trace_checker.sv
// Compares CPU writeback commits against a reference trace ROM and reports PASS/FAIL.
// Latency: ROM read data one cycle after trace_ren; verdict registered one edge after the deciding cycle.
// Backpressure: none toward the CPU; prefetch keeps two entries ahead so one commit per cycle is sustained.
module trace_checker
    import trace_chk_pkg::*;
#(
    parameter logic [31:0] END_PC      = END_PC_DEFAULT,
    parameter int          TRACE_AW    = 16,
    parameter bit          STOP_ON_ERR = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                chk_en,
    input  logic [31:0]         debug_wb_pc,
    input  logic [3:0]          debug_wb_rf_we,
    input  logic [4:0]          debug_wb_rf_wnum,
    input  logic [31:0]         debug_wb_rf_wdata,
    output logic                trace_ren,
    output logic [TRACE_AW-1:0] trace_raddr,
    input  logic [ENTRY_W-1:0]  trace_rdata,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_cnt,
    output logic [31:0]         commit_cnt,
    output logic [31:0]         err_pc,
    output logic [31:0]         err_wdata,
    output logic                underflow
);

    chk_state_t          state;
    chk_state_t          state_nxt;
    logic [TRACE_AW-1:0] rd_ptr;
    logic                inflight;
    logic [1:0]          occ;
    logic [ENTRY_W-1:0]  head;
    logic                in_run;
    logic                commit;
    logic                pop;
    logic                push;
    logic                under_evt;
    logic                mismatch;
    logic                err_evt;
    logic                at_end;
    logic [15:0]         err_cnt_nxt;

    trace_prefetch_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (trace_rdata),
        .pop       (pop),
        .head      (head),
        .occupancy (occ)
    );

    assign in_run    = (state == ST_RUN);
    assign commit    = in_run && (debug_wb_rf_we != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    assign pop       = commit && (occ != 2'd0);
    assign under_evt = commit && (occ == 2'd0);
    assign mismatch  = pop && ((debug_wb_pc != head[PC_MSB:PC_LSB]) ||
                               (debug_wb_rf_wnum != head[WNUM_MSB:WNUM_LSB]) ||
                               (((debug_wb_rf_wdata ^ head[WDATA_MSB:0]) &
                                 byte_mask(debug_wb_rf_we)) != 32'd0));
    assign err_evt   = mismatch || under_evt;
    assign at_end    = in_run && (debug_wb_pc == END_PC);
    // Data returning after RUN has ended is dropped here.
    assign push      = inflight && in_run;
    assign err_cnt_nxt = (err_evt && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;
    assign trace_raddr = rd_ptr;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state: errors that end the run win; END_PC folds in this cycle's compare.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (chk_en) state_nxt = ST_RUN;
            ST_RUN: begin
                if (under_evt || (mismatch && STOP_ON_ERR)) begin
                    state_nxt = ST_FAIL;
                end else if (at_end) begin
                    state_nxt = ((err_cnt_nxt == 16'd0) && !underflow) ? ST_PASS : ST_FAIL;
                end
            end
            default: state_nxt = state;
        endcase
    end

    // Fetch when buffered plus in-flight entries, net of this cycle's pop, fall below two.
    always_comb begin
        trace_ren = 1'b0;
        if (in_run) begin
            trace_ren = (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
        end
    end

    // Verdict outputs registered from the next state so they align with PASS/FAIL.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            done <= (state_nxt == ST_PASS) || (state_nxt == ST_FAIL);
            pass <= (state_nxt == ST_PASS);
        end
    end

    // Read pointer, in-flight flag, counters and first-error capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr     <= '0;
            inflight   <= 1'b0;
            err_cnt    <= 16'd0;
            commit_cnt <= 32'd0;
            err_pc     <= 32'd0;
            err_wdata  <= 32'd0;
            underflow  <= 1'b0;
        end else begin
            inflight <= trace_ren;
            if (trace_ren) rd_ptr <= rd_ptr + TRACE_AW'(1);
            if (pop) commit_cnt <= commit_cnt + 32'd1;
            err_cnt <= err_cnt_nxt;
            if (under_evt) underflow <= 1'b1;
            if (mismatch && (err_cnt == 16'd0)) begin
                err_pc    <= debug_wb_pc;
                err_wdata <= debug_wb_rf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: directed sequences, a vector table and a randomized run.
// Two instances: a = STOP_ON_ERR=1 with 3-bit ROM address, b = STOP_ON_ERR=0 with 16-bit address.
// Both share CPU stimulus and read the same 8-entry ROM model.
module tb_trace_checker;
    import trace_chk_pkg::*;

    localparam logic [31:0] END_PC = 32'h1c000100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        chk_en;
    logic [31:0] wb_pc;
    logic [3:0]  wb_we;
    logic [4:0]  wb_wnum;
    logic [31:0] wb_wdata;

    logic        ren_a, done_a, pass_a, uf_a;
    logic [2:0]  raddr_a;
    logic [68:0] rdata_a;
    logic [15:0] errc_a;
    logic [31:0] cc_a, epc_a, ewd_a;

    logic        ren_b, done_b, pass_b, uf_b;
    logic [15:0] raddr_b;
    logic [68:0] rdata_b;
    logic [15:0] errc_b;
    logic [31:0] cc_b, epc_b, ewd_b;

    logic [68:0] rom [8];

    trace_checker #(.END_PC(END_PC), .TRACE_AW(3), .STOP_ON_ERR(1'b1)) dut_a (
        .clk(clk), .reset(reset), .chk_en(chk_en),
        .debug_wb_pc(wb_pc), .debug_wb_rf_we(wb_we), .debug_wb_rf_wnum(wb_wnum),
        .debug_wb_rf_wdata(wb_wdata),
        .trace_ren(ren_a), .trace_raddr(raddr_a), .trace_rdata(rdata_a),
        .done(done_a), .pass(pass_a), .err_cnt(errc_a), .commit_cnt(cc_a),
        .err_pc(epc_a), .err_wdata(ewd_a), .underflow(uf_a)
    );

    trace_checker #(.END_PC(END_PC), .TRACE_AW(16), .STOP_ON_ERR(1'b0)) dut_b (
        .clk(clk), .reset(reset), .chk_en(chk_en),
        .debug_wb_pc(wb_pc), .debug_wb_rf_we(wb_we), .debug_wb_rf_wnum(wb_wnum),
        .debug_wb_rf_wdata(wb_wdata),
        .trace_ren(ren_b), .trace_raddr(raddr_b), .trace_rdata(rdata_b),
        .done(done_b), .pass(pass_b), .err_cnt(errc_b), .commit_cnt(cc_b),
        .err_pc(epc_b), .err_wdata(ewd_b), .underflow(uf_b)
    );

    // Synchronous ROM: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (ren_a) rdata_a <= rom[raddr_a];
        if (ren_b) rdata_b <= rom[raddr_b[2:0]];
    end

    // Watch instance a's read addresses for a 7 -> 0 wrap.
    logic [2:0] last_a;
    bit         last_vld;
    bit         wrap_seen;
    always @(negedge clk) begin
        if (ren_a) begin
            if (last_vld && last_a == 3'd7 && raddr_a == 3'd0) wrap_seen = 1'b1;
            last_a   = raddr_a;
            last_vld = 1'b1;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] we, input logic [4:0] wn,
                         input logic [31:0] pc, input logic [31:0] wd);
        wb_we = we; wb_wnum = wn; wb_pc = pc; wb_wdata = wd;
        tick();
    endtask

    task automatic idle_cycle();
        drive(4'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1; chk_en = 1'b0;
        wb_we = 4'd0; wb_wnum = 5'd0; wb_pc = 32'd0; wb_wdata = 32'd0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Leaves the bench in the second cycle after RUN entry, when one entry is buffered.
    task automatic start_run();
        chk_en = 1'b1; tick();
        chk_en = 1'b0; tick(); tick();
    endtask

    task automatic commit_rom(input int i, input logic [3:0] we, input logic [31:0] dx);
        logic [68:0] e;
        e = rom[3'(i)];
        drive(we, e[68:64], e[63:32], e[31:0] ^ dx);
    endtask

    task automatic end_run();
        drive(4'd0, 5'd0, END_PC, 32'd0);
        wb_pc = 32'd0;
    endtask

    typedef struct {
        logic [3:0]  we;
        bit          zero_wnum;
        logic [4:0]  wnum_add;
        logic [31:0] pc_x;
        logic [31:0] dx;
        bit          exp_chk;
        bit          exp_err;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [68:0] e;
        logic [31:0] pcv, dv, fpc, fwd, r;
        logic [4:0]  wn;
        logic [3:0]  we;
        int          k, exp_cc, exp_err, sel;
        bit          got_first, mism;

        tbl[0] = '{4'hF, 1'b0, 5'd0, 32'h0,  32'h0,        1'b1, 1'b0};
        tbl[1] = '{4'h1, 1'b0, 5'd0, 32'h0,  32'hFFFFFF00, 1'b1, 1'b0};
        tbl[2] = '{4'h1, 1'b0, 5'd0, 32'h0,  32'h00000001, 1'b1, 1'b1};
        tbl[3] = '{4'h0, 1'b0, 5'd0, 32'h0,  32'h0,        1'b0, 1'b0};
        tbl[4] = '{4'hF, 1'b1, 5'd0, 32'h0,  32'h0,        1'b0, 1'b0};
        tbl[5] = '{4'h8, 1'b0, 5'd0, 32'h0,  32'h00FFFFFF, 1'b1, 1'b0};
        tbl[6] = '{4'h2, 1'b0, 5'd0, 32'h0,  32'h00000100, 1'b1, 1'b1};
        tbl[7] = '{4'hF, 1'b0, 5'd0, 32'h10, 32'h0,        1'b1, 1'b1};
        tbl[8] = '{4'hF, 1'b0, 5'd1, 32'h0,  32'h0,        1'b1, 1'b1};
        tbl[9] = '{4'h3, 1'b0, 5'd0, 32'h0,  32'hFFFF0000, 1'b1, 1'b0};

        for (int i = 0; i < 8; i++) begin
            rom[i] = {5'(i + 1), 32'h1c000000 + 32'(i * 4), 32'h11111111 * 32'(i + 1)};
        end
        last_vld = 1'b0; wrap_seen = 1'b0;

        // Reset state
        do_reset();
        chk("rst_done",   32'(done_a), 32'd0);
        chk("rst_pass",   32'(pass_a), 32'd0);
        chk("rst_errcnt", 32'(errc_a), 32'd0);
        chk("rst_commit", cc_a, 32'd0);
        chk("rst_errpc",  epc_a, 32'd0);
        chk("rst_uflow",  32'(uf_a), 32'd0);
        chk("rst_ren",    32'(ren_a), 32'd0);

        // Eight clean back-to-back commits then END_PC
        start_run();
        for (int i = 0; i < 8; i++) commit_rom(i, 4'hF, 32'd0);
        end_run();
        chk("clean_commit", cc_a, 32'd8);
        chk("clean_errcnt", 32'(errc_a), 32'd0);
        chk("clean_done",   32'(done_a), 32'd1);
        chk("clean_pass",   32'(pass_a), 32'd1);

        // Ten commits with a 3-bit address: wrapped entries must still compare clean
        do_reset();
        last_vld = 1'b0; wrap_seen = 1'b0;
        start_run();
        for (int i = 0; i < 10; i++) commit_rom(i, 4'hF, 32'd0);
        chk("wrap_commit", cc_a, 32'd10);
        chk("wrap_errcnt", 32'(errc_a), 32'd0);
        end_run();
        chk("wrap_pass", 32'(pass_a), 32'd1);
        chk("wrap_seen", 32'(wrap_seen), 32'd1);

        // Stop on first error: entry 3 off in bit 0
        do_reset();
        start_run();
        for (int i = 0; i < 3; i++) commit_rom(i, 4'hF, 32'd0);
        chk("stop_done_before", 32'(done_a), 32'd0);
        commit_rom(3, 4'hF, 32'd1);
        e = rom[3];
        chk("stop_errcnt", 32'(errc_a), 32'd1);
        chk("stop_errpc",  epc_a, e[63:32]);
        chk("stop_errwd",  ewd_a, e[31:0] ^ 32'd1);
        chk("stop_commit", cc_a, 32'd4);
        chk("stop_done",   32'(done_a), 32'd1);
        chk("stop_pass",   32'(pass_a), 32'd0);
        for (int i = 4; i < 8; i++) commit_rom(i, 4'hF, 32'd0);
        end_run();
        chk("stop_commit_after", cc_a, 32'd4);
        chk("stop_errcnt_after", 32'(errc_a), 32'd1);
        chk("stop_pass_after",   32'(pass_a), 32'd0);

        // Commit in the first RUN cycle with nothing buffered
        do_reset();
        chk_en = 1'b1; tick();
        chk_en = 1'b0;
        commit_rom(0, 4'hF, 32'd0);
        chk("uf_flag",   32'(uf_a), 32'd1);
        chk("uf_done",   32'(done_a), 32'd1);
        chk("uf_pass",   32'(pass_a), 32'd0);
        chk("uf_errcnt", 32'(errc_a), 32'd1);
        chk("uf_commit", cc_a, 32'd0);

        // Vector table on the non-stopping instance
        do_reset();
        start_run();
        k = 0; exp_cc = 0; exp_err = 0; got_first = 1'b0; fpc = '0; fwd = '0;
        for (int j = 0; j < 10; j++) begin
            e   = rom[3'(k)];
            pcv = e[63:32] ^ tbl[j].pc_x;
            wn  = tbl[j].zero_wnum ? 5'd0 : e[68:64] + tbl[j].wnum_add;
            dv  = e[31:0] ^ tbl[j].dx;
            if (tbl[j].exp_err && !got_first) begin
                fpc = pcv; fwd = dv; got_first = 1'b1;
            end
            drive(tbl[j].we, wn, pcv, dv);
            if (tbl[j].exp_chk) k++;
            exp_cc  += int'(tbl[j].exp_chk);
            exp_err += int'(tbl[j].exp_err);
            chk($sformatf("tbl%0d_commit", j), cc_b, 32'(exp_cc));
            chk($sformatf("tbl%0d_errcnt", j), 32'(errc_b), 32'(exp_err));
        end
        end_run();
        chk("tbl_errpc", epc_b, fpc);
        chk("tbl_errwd", ewd_b, fwd);
        chk("tbl_done",  32'(done_b), 32'd1);
        chk("tbl_pass",  32'(pass_b), 32'd0);

        // Reset while running with two entries buffered and an error recorded
        do_reset();
        start_run();
        commit_rom(0, 4'hF, 32'h4);
        idle_cycle(); idle_cycle();
        chk("mid_errcnt_pre", 32'(errc_b), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_done",   32'(done_b), 32'd0);
        chk("mid_pass",   32'(pass_b), 32'd0);
        chk("mid_errcnt", 32'(errc_b), 32'd0);
        chk("mid_commit", cc_b, 32'd0);
        chk("mid_errpc",  epc_b, 32'd0);
        chk("mid_errwd",  ewd_b, 32'd0);
        chk("mid_uflow",  32'(uf_b), 32'd0);
        chk_en = 1'b1; #1;
        chk("mid_idle_ren", 32'(ren_b), 32'd0);
        tick();
        chk_en = 1'b0; #1;
        chk("mid_first_ren",   32'(ren_b), 32'd1);
        chk("mid_first_raddr", 32'(raddr_b), 32'd0);

        // Randomized run against a reference model of the expected-entry stream
        do_reset();
        for (int i = 0; i < 8; i++) begin
            r = $urandom();
            rom[i] = {5'($urandom_range(1, 31)), r | 32'd1, 32'($urandom())};
        end
        start_run();
        k = 0; exp_cc = 0; exp_err = 0; fpc = '0; fwd = '0;
        for (int c = 0; c < 300; c++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                e   = rom[3'(k)];
                we  = 4'($urandom_range(1, 15));
                pcv = e[63:32];
                dv  = e[31:0];
                wn  = e[68:64];
                if ($urandom_range(0, 3) == 0) dv = dv ^ (32'd1 << $urandom_range(0, 31));
                if ($urandom_range(0, 9) == 0) pcv = pcv ^ (32'd1 << $urandom_range(1, 31));
                mism = (pcv != e[63:32]);
                for (int b = 0; b < 4; b++) begin
                    if (we[b] && (dv[8*b +: 8] != e[8*b +: 8])) mism = 1'b1;
                end
                if (mism) begin
                    if (exp_err == 0) begin fpc = pcv; fwd = dv; end
                    exp_err++;
                end
                k++; exp_cc++;
            end else if (sel < 8) begin
                r = $urandom();
                if ($urandom_range(0, 1) == 0) begin
                    we = 4'd0; wn = 5'($urandom_range(1, 31));
                end else begin
                    we = 4'($urandom_range(1, 15)); wn = 5'd0;
                end
                pcv = r | 32'd1;
                dv  = $urandom();
            end else begin
                we = 4'd0; wn = 5'd0; pcv = 32'd0; dv = 32'd0;
            end
            drive(we, wn, pcv, dv);
            chk("rnd_commit", cc_b, 32'(exp_cc));
            chk("rnd_errcnt", 32'(errc_b), 32'(exp_err));
        end
        if (exp_err > 0) begin
            chk("rnd_errpc", epc_b, fpc);
            chk("rnd_errwd", ewd_b, fwd);
        end
        end_run();
        chk("rnd_done", 32'(done_b), 32'd1);
        chk("rnd_pass", 32'(pass_b), 32'(exp_err == 0));
        chk("rnd_uflow", 32'(uf_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
